// File: rtl/rename_pkg.sv
// Shared types and helpers for the rename freelist allocation controller.
package rename_pkg;

    localparam int PHY_REGS_DEF  = 64;
    localparam int PHY_WIDTH_DEF = 6;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } alloc_state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/free_port_merger.sv
// Drops PHY_ZERO entries and packs up to 3 commit + 2 recovery frees onto 3 ports, commit first.
module free_port_merger
    import rename_pkg::*;
#(
    parameter int PHY_WIDTH = PHY_WIDTH_DEF
) (
    input  logic [2:0]                cm_valid,
    input  logic [2:0][PHY_WIDTH-1:0] cm_phy,
    input  logic [1:0]                rcv_valid,
    input  logic [1:0][PHY_WIDTH-1:0] rcv_phy,
    output logic [2:0]                out_valid,
    output logic [2:0][PHY_WIDTH-1:0] out_phy
);

    logic [4:0]                in_valid;
    logic [4:0][PHY_WIDTH-1:0] in_phy;

    assign in_valid = {rcv_valid, cm_valid};
    assign in_phy   = {rcv_phy, cm_phy};

    always_comb begin
        logic [2:0] slot;
        out_valid = '0;
        out_phy   = '0;
        slot      = '0;
        for (int i = 0; i < 5; i++) begin
            if (in_valid[i] && (in_phy[i] != '0) && (slot < 3'd3)) begin
                out_valid[slot[1:0]] = 1'b1;
                out_phy[slot[1:0]]   = in_phy[i];
                slot                 = slot + 3'd1;
            end
        end
    end

endmodule

// File: rtl/freelist_alloc_ctrl.sv
// Rename allocation grant, free-port arbitration and recovery sequencing for the freelist.
// Optional sticky error checking is enabled with `define ALLOC_CTRL_CHECK_EN.
module freelist_alloc_ctrl
    import rename_pkg::*;
#(
    parameter int PHY_REGS  = PHY_REGS_DEF,
    parameter int PHY_WIDTH = PHY_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           rn_req,
    output logic [1:0]           rn_gnt,
    output logic                 rn_stall,
    output logic [1:0]           fl_alloc_valid,
    input  logic [2:0]           cm_free_valid,
    input  logic [PHY_WIDTH-1:0] cm_free_0,
    input  logic [PHY_WIDTH-1:0] cm_free_1,
    input  logic [PHY_WIDTH-1:0] cm_free_2,
    input  logic                 flush,
    input  logic [1:0]           rcv_valid,
    input  logic [PHY_WIDTH-1:0] rcv_phy_0,
    input  logic [PHY_WIDTH-1:0] rcv_phy_1,
    output logic                 rcv_ready,
    input  logic                 rcv_done,
    output logic [2:0]           fl_free_valid,
    output logic [PHY_WIDTH-1:0] fl_free_0,
    output logic [PHY_WIDTH-1:0] fl_free_1,
    output logic [PHY_WIDTH-1:0] fl_free_2,
    output logic [PHY_WIDTH:0]   free_count,
    output logic                 busy,
    output logic                 err
);

    alloc_state_t              state;
    logic [1:0]                req_cnt;
    logic [1:0]                gnt_cnt;
    logic [1:0]                free_cnt;
    logic [1:0]                rcv_accept;
    logic [2:0]                merged_valid;
    logic [2:0][PHY_WIDTH-1:0] merged_phy;
    logic [PHY_WIDTH+1:0]      count_next;

    assign req_cnt = popcount3({1'b0, rn_req});

    // Commit frees keep priority; recovery only fits when at most one commit port is used.
    assign rcv_ready  = !rst && (state == RECOVER) && (popcount3(cm_free_valid) <= 2'd1);
    assign rcv_accept = rcv_ready ? rcv_valid : 2'b00;

    // All-or-nothing grant against the registered count; flush beats rename.
    always_comb begin
        rn_gnt = 2'b00;
        if (!rst && (state == IDLE) && !flush &&
            ({{(PHY_WIDTH-1){1'b0}}, req_cnt} <= free_count))
            rn_gnt = rn_req;
    end

    assign rn_stall       = !rst && (|rn_req) && !(|rn_gnt);
    assign fl_alloc_valid = rn_gnt;

    free_port_merger #(.PHY_WIDTH(PHY_WIDTH)) u_merger (
        .cm_valid  (cm_free_valid),
        .cm_phy    ({cm_free_2, cm_free_1, cm_free_0}),
        .rcv_valid (rcv_accept),
        .rcv_phy   ({rcv_phy_1, rcv_phy_0}),
        .out_valid (merged_valid),
        .out_phy   (merged_phy)
    );

    assign fl_free_valid = rst ? 3'b000 : merged_valid;
    assign fl_free_0     = rst ? '0 : merged_phy[0];
    assign fl_free_1     = rst ? '0 : merged_phy[1];
    assign fl_free_2     = rst ? '0 : merged_phy[2];

    assign gnt_cnt    = popcount3({1'b0, rn_gnt});
    assign free_cnt   = popcount3(fl_free_valid);
    assign count_next = {1'b0, free_count} - {{PHY_WIDTH{1'b0}}, gnt_cnt}
                      + {{PHY_WIDTH{1'b0}}, free_cnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            free_count <= (PHY_WIDTH+1)'(PHY_REGS - 1);
        end else begin
            free_count <= count_next[PHY_WIDTH:0];
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= RECOVER;
                        busy  <= 1'b1;
                    end
                end
                RECOVER: begin
                    // A flush mid-walk restarts the walk, so it overrides rcv_done.
                    if (!flush && rcv_done && rcv_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALLOC_CTRL_CHECK_EN
    logic ev_overflow;
    logic ev_noncontig;
    logic ev_zero;
    logic ev_stray;

    assign ev_overflow  = count_next > (PHY_WIDTH+2)'(PHY_REGS - 1);
    assign ev_noncontig = !(cm_free_valid inside {3'b000, 3'b001, 3'b011, 3'b111}) ||
                          (rcv_valid == 2'b10);
    assign ev_zero      = (cm_free_valid[0] && (cm_free_0 == '0)) ||
                          (cm_free_valid[1] && (cm_free_1 == '0)) ||
                          (cm_free_valid[2] && (cm_free_2 == '0)) ||
                          (rcv_valid[0] && (rcv_phy_0 == '0)) ||
                          (rcv_valid[1] && (rcv_phy_1 == '0));
    assign ev_stray     = (state != RECOVER) && (|rcv_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (ev_overflow || ev_noncontig || ev_zero || ev_stray) begin
            err <= 1'b1;
            if (ev_overflow)  $error("freelist_alloc_ctrl: free count overflow");
            if (ev_noncontig) $error("freelist_alloc_ctrl: non-contiguous free/recovery valid");
            if (ev_zero)      $error("freelist_alloc_ctrl: free of PHY_ZERO");
            if (ev_stray)     $error("freelist_alloc_ctrl: rcv_valid outside RECOVER");
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_freelist_alloc_ctrl.sv
// Directed bench for freelist_alloc_ctrl with a queue-based reference model checked every cycle.
module tb_freelist_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rn_req;
    logic [1:0] rn_gnt;
    logic       rn_stall;
    logic [1:0] fl_alloc_valid;
    logic [2:0] cm_free_valid;
    logic [5:0] cm_free_0, cm_free_1, cm_free_2;
    logic       flush;
    logic [1:0] rcv_valid;
    logic [5:0] rcv_phy_0, rcv_phy_1;
    logic       rcv_ready;
    logic       rcv_done;
    logic [2:0] fl_free_valid;
    logic [5:0] fl_free_0, fl_free_1, fl_free_2;
    logic [6:0] free_count;
    logic       busy;
    logic       err;

    int checks   = 0;
    int failures = 0;

`ifdef ALLOC_CTRL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    freelist_alloc_ctrl #(.PHY_REGS(64), .PHY_WIDTH(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .rn_req         (rn_req),
        .rn_gnt         (rn_gnt),
        .rn_stall       (rn_stall),
        .fl_alloc_valid (fl_alloc_valid),
        .cm_free_valid  (cm_free_valid),
        .cm_free_0      (cm_free_0),
        .cm_free_1      (cm_free_1),
        .cm_free_2      (cm_free_2),
        .flush          (flush),
        .rcv_valid      (rcv_valid),
        .rcv_phy_0      (rcv_phy_0),
        .rcv_phy_1      (rcv_phy_1),
        .rcv_ready      (rcv_ready),
        .rcv_done       (rcv_done),
        .fl_free_valid  (fl_free_valid),
        .fl_free_0      (fl_free_0),
        .fl_free_1      (fl_free_1),
        .fl_free_2      (fl_free_2),
        .free_count     (free_count),
        .busy           (busy),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: free count as an integer, recovery as a flag, frees as a queue.
    bit m_ok  = 1'b0;
    bit m_rec = 1'b0;
    bit m_err = 1'b0;
    int m_cnt = 63;
    int n_cnt;
    bit n_rec, n_err;
    int q[$];
    int cp[3];
    int rp[2];
    int e_gnt, e_stall, e_ready, e_fv, ev;

    always @(negedge clk) begin
        cp[0] = cm_free_0; cp[1] = cm_free_1; cp[2] = cm_free_2;
        rp[0] = rcv_phy_0; rp[1] = rcv_phy_1;
        e_gnt = 0;
        if (!rst && !m_rec && !flush && $countones(rn_req) <= m_cnt) e_gnt = rn_req;
        e_stall = (!rst && rn_req != 0 && e_gnt == 0) ? 1 : 0;
        e_ready = (!rst && m_rec && $countones(cm_free_valid) <= 1) ? 1 : 0;
        q.delete();
        for (int i = 0; i < 3; i++)
            if (cm_free_valid[i] && cp[i] != 0) q.push_back(cp[i]);
        if (e_ready != 0)
            for (int i = 0; i < 2; i++)
                if (rcv_valid[i] && rp[i] != 0) q.push_back(rp[i]);
        if (rst) q.delete();
        e_fv = (1 << q.size()) - 1;

        chk("rn_gnt", int'(rn_gnt), e_gnt);
        chk("fl_alloc_valid", int'(fl_alloc_valid), e_gnt);
        chk("rn_stall", int'(rn_stall), e_stall);
        chk("rcv_ready", int'(rcv_ready), e_ready);
        chk("fl_free_valid", int'(fl_free_valid), e_fv);
        if (q.size() > 0) chk("fl_free_0", int'(fl_free_0), q[0]);
        if (q.size() > 1) chk("fl_free_1", int'(fl_free_1), q[1]);
        if (q.size() > 2) chk("fl_free_2", int'(fl_free_2), q[2]);
        if (m_ok) begin
            chk("free_count", int'(free_count), m_cnt);
            chk("busy", int'(busy), int'(m_rec));
            chk("err", int'(err), int'(m_err));
        end

        n_cnt = m_cnt - $countones(e_gnt) + q.size();
        if (!m_rec) n_rec = flush;
        else        n_rec = flush || !(rcv_done && e_ready != 0);
        ev = 0;
        if (n_cnt > 63) ev = 1;
        if (!(cm_free_valid inside {3'b000, 3'b001, 3'b011, 3'b111})) ev = 1;
        if (rcv_valid == 2'b10) ev = 1;
        for (int i = 0; i < 3; i++) if (cm_free_valid[i] && cp[i] == 0) ev = 1;
        for (int i = 0; i < 2; i++) if (rcv_valid[i] && rp[i] == 0) ev = 1;
        if (!m_rec && rcv_valid != 0) ev = 1;
        n_err = m_err || (CHK_EN && ev != 0);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_cnt <= 63;
            m_rec <= 1'b0;
            m_err <= 1'b0;
            m_ok  <= 1'b1;
        end else if (m_ok) begin
            m_cnt <= n_cnt;
            m_rec <= n_rec;
            m_err <= n_err;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rn_req = 2'b00; flush = 1'b0; rcv_done = 1'b0;
        cm_free_valid = 3'b000; cm_free_0 = '0; cm_free_1 = '0; cm_free_2 = '0;
        rcv_valid = 2'b00; rcv_phy_0 = '0; rcv_phy_1 = '0;
        step(); step();
        @(negedge clk);
        chk("lit_rst_count", int'(free_count), 63);
        chk("lit_rst_busy", int'(busy), 0);
        chk("lit_rst_err", int'(err), 0);
        chk("lit_rst_gnt", int'(rn_gnt), 0);

        step(); rst = 1'b0; rn_req = 2'b11;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            chk("lit_grant11", int'(rn_gnt), 3);
            step();
        end
        @(negedge clk);
        chk("lit_count1", int'(free_count), 1);
        chk("lit_stall11", int'(rn_stall), 1);
        chk("lit_nogrant11", int'(rn_gnt), 0);

        step(); rn_req = 2'b10;
        @(negedge clk);
        chk("lit_grant10", int'(rn_gnt), 2);

        step(); rn_req = 2'b01;
        @(negedge clk);
        chk("lit_count0", int'(free_count), 0);
        chk("lit_stall_at0", int'(rn_stall), 1);

        step(); rn_req = 2'b00; cm_free_valid = 3'b001; cm_free_0 = 6'd5;
        @(negedge clk);
        chk("lit_free5_valid", int'(fl_free_valid), 1);
        chk("lit_free5_phy", int'(fl_free_0), 5);

        // Simultaneous alloc and free leaves the count unchanged.
        step(); rn_req = 2'b01; cm_free_0 = 6'd10;
        @(negedge clk);
        chk("lit_count_after_free", int'(free_count), 1);
        chk("lit_grant_simul", int'(rn_gnt), 1);

        step(); rn_req = 2'b11; cm_free_valid = 3'b000; flush = 1'b1;
        @(negedge clk);
        chk("lit_flush_gnt", int'(rn_gnt), 0);
        chk("lit_flush_stall", int'(rn_stall), 1);

        step(); rn_req = 2'b00; flush = 1'b0; rcv_valid = 2'b11; rcv_phy_0 = 6'd7; rcv_phy_1 = 6'd9;
        @(negedge clk);
        chk("lit_rec_busy", int'(busy), 1);
        chk("lit_rec_ready", int'(rcv_ready), 1);
        chk("lit_rec_fv", int'(fl_free_valid), 3);
        chk("lit_rec_f0", int'(fl_free_0), 7);
        chk("lit_rec_f1", int'(fl_free_1), 9);

        step(); rcv_phy_0 = 6'd11; rcv_phy_1 = 6'd12; rcv_done = 1'b1;
        cm_free_valid = 3'b011; cm_free_0 = 6'd3; cm_free_1 = 6'd4;
        @(negedge clk);
        chk("lit_count_plus2", int'(free_count), 3);
        chk("lit_blocked_ready", int'(rcv_ready), 0);
        chk("lit_cm_f0", int'(fl_free_0), 3);
        chk("lit_cm_f1", int'(fl_free_1), 4);

        step(); cm_free_valid = 3'b000;
        @(negedge clk);
        chk("lit_retry_ready", int'(rcv_ready), 1);
        chk("lit_retry_f0", int'(fl_free_0), 11);
        chk("lit_still_busy", int'(busy), 1);

        step(); rcv_valid = 2'b00; rcv_done = 1'b0;
        @(negedge clk);
        chk("lit_idle_busy", int'(busy), 0);
        chk("lit_count7", int'(free_count), 7);

        step(); cm_free_valid = 3'b111; cm_free_0 = 6'd0; cm_free_1 = 6'd6; cm_free_2 = 6'd8;
        @(negedge clk);
        chk("lit_zero_fv", int'(fl_free_valid), 3);
        chk("lit_zero_f0", int'(fl_free_0), 6);
        chk("lit_zero_f1", int'(fl_free_1), 8);

        step(); cm_free_valid = 3'b000;
        @(negedge clk);
        chk("lit_count9", int'(free_count), 9);
        chk("lit_err_sticky", int'(err), CHK_EN ? 1 : 0);

        // Flush inside RECOVER overrides rcv_done.
        step(); flush = 1'b1;
        step(); rcv_done = 1'b1;
        @(negedge clk);
        chk("lit_flush_rec_busy", int'(busy), 1);
        step(); flush = 1'b0; rcv_done = 1'b0; rcv_valid = 2'b01; rcv_phy_0 = 6'd20;
        @(negedge clk);
        chk("lit_flush_stays", int'(busy), 1);

        step(); rst = 1'b1; rcv_valid = 2'b00;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_mid_busy", int'(busy), 0);
        chk("lit_rst_mid_count", int'(free_count), 63);
        chk("lit_rst_mid_err", int'(err), 0);

        step(); step();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
